// File: rtl/spi_frame_sched_if.sv
// Bundle of requester, serializer and status signals for spi_frame_sched.
// slave is the scheduler side; master is the requester/serializer side.
interface spi_frame_sched_if;
  logic       r0_req;
  logic [7:0] r0_cmd;
  logic [7:0] r0_data;
  logic       r0_valid;
  logic       r0_last;
  logic       r0_ready;
  logic       r1_req;
  logic [7:0] r1_cmd;
  logic [7:0] r1_data;
  logic       r1_valid;
  logic       r1_last;
  logic       r1_ready;
  logic [1:0] grant;
  logic [1:0] cs_n;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;
  logic       busy;

  modport slave (
    input  r0_req, r0_cmd, r0_data, r0_valid, r0_last,
    input  r1_req, r1_cmd, r1_data, r1_valid, r1_last,
    input  tx_done,
    output r0_ready, r1_ready, grant, cs_n, tx_data, tx_send, busy
  );

  modport master (
    output r0_req, r0_cmd, r0_data, r0_valid, r0_last,
    output r1_req, r1_cmd, r1_data, r1_valid, r1_last,
    output tx_done,
    input  r0_ready, r1_ready, grant, cs_n, tx_data, tx_send, busy
  );
endinterface

// File: rtl/spi_frame_sched.sv
// Two-requester SPI frame scheduler: round-robin arbitration, chip-select
// lead time, command byte, payload bytes one at a time, and inter-frame gap.
module spi_frame_sched #(
  parameter int unsigned CS_LEAD = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input logic              clk,
  input logic              rst,
  spi_frame_sched_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle, StLead, StCmd, StCmdWait, StData, StDataWait, StEnd, StGap
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        owner_q, owner_d;          // 1: requester 1 owns the frame
  logic        last_grant_q, last_grant_d;
  logic        byte_last_q, byte_last_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_send;
  logic        r0_ready, r1_ready, accept, pick;
  logic [7:0]  sel_data;
  logic        sel_last;

  assign r0_ready = (state_q == StData) && grant_q[0] && bus_io.r0_valid;
  assign r1_ready = (state_q == StData) && grant_q[1] && bus_io.r1_valid;
  assign accept   = r0_ready || r1_ready;
  assign sel_data = grant_q[1] ? bus_io.r1_data : bus_io.r0_data;
  assign sel_last = grant_q[1] ? bus_io.r1_last : bus_io.r0_last;
  // Contention goes to whoever did not own the previous frame.
  assign pick     = (bus_io.r0_req && bus_io.r1_req) ? ~last_grant_q : bus_io.r1_req;

  // Next-state, counters, latches and the send strobe.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    byte_last_d  = byte_last_q;
    cmd_d        = cmd_q;
    tx_data_d    = tx_data_q;
    tx_send      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.r0_req || bus_io.r1_req) begin
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          cmd_d   = pick ? bus_io.r1_cmd : bus_io.r0_cmd;
          cnt_d   = 16'(CS_LEAD);
          state_d = StLead;
        end
      end
      StLead: begin
        if (cnt_q <= 16'd1) begin
          cnt_d   = '0;
          state_d = StCmd;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StCmd: begin
        tx_send   = 1'b1;
        tx_data_d = cmd_q;
        state_d   = StCmdWait;
      end
      StCmdWait: begin
        if (bus_io.tx_done) state_d = StData;
      end
      StData: begin
        if (accept) begin
          tx_send     = 1'b1;
          tx_data_d   = sel_data;
          byte_last_d = sel_last;
          state_d     = StDataWait;
        end
      end
      StDataWait: begin
        if (bus_io.tx_done) begin
          if (byte_last_q) begin
            grant_d = 2'b00;
            state_d = StEnd;
          end else begin
            state_d = StData;
          end
        end
      end
      StEnd: begin
        last_grant_d = owner_q;
        cnt_d        = 16'(CS_GAP);
        state_d      = StGap;
      end
      StGap: begin
        if (cnt_q <= 16'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_q      <= 2'b00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      byte_last_q  <= 1'b0;
      cmd_q        <= 8'h00;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      byte_last_q  <= byte_last_d;
      cmd_q        <= cmd_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Grant is one-hot or zero, so at most one chip select is ever low.
  assign bus_io.grant    = grant_q;
  assign bus_io.cs_n     = ~grant_q;
  assign bus_io.tx_data  = tx_data_d;
  assign bus_io.tx_send  = tx_send;
  assign bus_io.r0_ready = r0_ready;
  assign bus_io.r1_ready = r1_ready;
  assign bus_io.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_frame_sched.sv
// Self-checking bench for spi_frame_sched: requester drivers, a serializer
// model with configurable latency, and a scoreboard of expected {cs_n, byte}.
module tb_spi_frame_sched;
  localparam int unsigned CsLead = 2;
  localparam int unsigned CsGap  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_frame_sched_if bus ();

  spi_frame_sched #(.CS_LEAD(CsLead), .CS_GAP(CsGap)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         send_count = 0;
  int         ser_cnt = 0;
  int         ser_lat = 3;
  int         cs_hi_run = 0;
  bit         ser_busy = 1'b0;
  bit         spur_pending = 1'b0;
  bit         seen_frame = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;

  // Serializer model and continuous monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      ser_busy   = 1'b0;
      ser_cnt    = 0;
      bus.tx_done = 1'b0;
      seen_frame = 1'b0;
      cs_hi_run  = 0;
    end else begin
      bus.tx_done = 1'b0;
      if (spur_pending) begin
        bus.tx_done  = 1'b1;
        spur_pending = 1'b0;
      end
      if (ser_busy) begin
        ser_cnt--;
        if (ser_cnt == 0) begin
          bus.tx_done = 1'b1;
          ser_busy    = 1'b0;
        end
      end
      total++;
      if (bus.cs_n === 2'b00) begin
        bad++;
        $display("FAIL cs_n_both_low: got %b required never 00", bus.cs_n);
      end
      total++;
      if ((bus.r0_ready === 1'b1 && bus.grant[0] !== 1'b1) ||
          (bus.r1_ready === 1'b1 && bus.grant[1] !== 1'b1)) begin
        bad++;
        $display("FAIL ready_not_granted: got ready=%b%b grant=%b required no ready without grant",
                 bus.r1_ready, bus.r0_ready, bus.grant);
      end
      if (bus.cs_n === 2'b11) begin
        cs_hi_run++;
      end else begin
        if (seen_frame && cs_hi_run > 0) begin
          total++;
          if (cs_hi_run < int'(CsGap)) begin
            bad++;
            $display("FAIL cs_gap: got %0d high cycles required >= %0d", cs_hi_run, CsGap);
          end
        end
        cs_hi_run  = 0;
        seen_frame = 1'b1;
      end
      if (bus.tx_send === 1'b1) begin
        total++;
        if (ser_busy) begin
          bad++;
          $display("FAIL outstanding: got tx_send while byte in flight required none");
        end
        send_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_send: got cs_n=%b data=%h required no send",
                   bus.cs_n, bus.tx_data);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.cs_n, bus.tx_data} !== exp_v) begin
            bad++;
            $display("FAIL send_seq: got cs_n=%b data=%h required cs_n=%b data=%h",
                     bus.cs_n, bus.tx_data, exp_v[9:8], exp_v[7:0]);
          end
        end
        ser_busy = 1'b1;
        ser_cnt  = ser_lat;
      end
    end
  end

  function automatic logic [7:0] byte_at(input logic [7:0] base, input bit incr, input int i);
    return incr ? base + 8'(i) : base;
  endfunction

  function automatic logic get_ready(input int who);
    return (who == 0) ? bus.r0_ready : bus.r1_ready;
  endfunction

  task automatic set_req(input int who, input logic v, input logic [7:0] c);
    if (who == 0) begin
      bus.r0_req = v;
      bus.r0_cmd = c;
    end else begin
      bus.r1_req = v;
      bus.r1_cmd = c;
    end
  endtask

  task automatic set_byte(input int who, input logic v, input logic [7:0] d, input logic l);
    if (who == 0) begin
      bus.r0_valid = v;
      bus.r0_data  = d;
      bus.r0_last  = l;
    end else begin
      bus.r1_valid = v;
      bus.r1_data  = d;
      bus.r1_last  = l;
    end
  endtask

  task automatic push_frame(input int who, input logic [7:0] cmd, input int n,
                            input logic [7:0] base, input bit incr);
    logic [1:0] cs;
    cs = (who == 0) ? 2'b10 : 2'b01;
    exp_q.push_back({cs, cmd});
    for (int i = 0; i < n; i++) exp_q.push_back({cs, byte_at(base, incr, i)});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Raise req, wait for this requester's grant, then drop req.
  task automatic start_frame(input int who, input logic [7:0] cmd, output bit ok);
    int         k;
    logic [1:0] g_exp;
    g_exp = (who == 0) ? 2'b01 : 2'b10;
    ok = 1'b0;
    k  = 0;
    @(posedge clk); #1;
    set_req(who, 1'b1, cmd);
    while (k < 5000) begin
      @(negedge clk);
      if (bus.grant[who] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      k++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL grant_wait_r%0d: got no grant in %0d cycles required grant", who, k);
    end else if ({bus.grant, bus.cs_n} !== {g_exp, ~g_exp}) begin
      bad++;
      $display("FAIL grant_r%0d: got grant=%b cs_n=%b required grant=%b cs_n=%b",
               who, bus.grant, bus.cs_n, g_exp, ~g_exp);
    end
    @(posedge clk); #1;
    set_req(who, 1'b0, cmd);
  endtask

  // Offer n payload bytes; optionally hold valid low for a while once in DATA.
  task automatic feed_bytes(input int who, input int n, input logic [7:0] base, input bit incr,
                            input int withhold, input bit spur);
    int         k;
    bit         got;
    logic [1:0] cs_exp;
    cs_exp = (who == 0) ? 2'b10 : 2'b01;
    if (withhold > 0) begin
      k = 0;
      while (k < 100 && bus.tx_send !== 1'b1) begin
        @(posedge clk); #1;
        k++;
      end
      k = 0;
      while (k < 100 && bus.tx_done !== 1'b1) begin
        @(posedge clk); #1;
        k++;
      end
      total++;
      if (k >= 100) begin
        bad++;
        $display("FAIL cmd_done_wait_r%0d: got no tx_done required command completion", who);
      end
      if (spur) spur_pending = 1'b1;
      for (int i = 0; i < withhold; i++) begin
        @(negedge clk);
        total++;
        if ({bus.cs_n, bus.tx_send, get_ready(who), bus.busy} !== {cs_exp, 1'b0, 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL withhold_r%0d: got cs_n=%b send=%b ready=%b busy=%b required %b 0 0 1",
                   who, bus.cs_n, bus.tx_send, get_ready(who), bus.busy, cs_exp);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      set_byte(who, 1'b1, byte_at(base, incr, i), (i == n - 1));
      got = 1'b0;
      k   = 0;
      while (k < 200) begin
        @(negedge clk);
        if (get_ready(who) === 1'b1) begin
          got = 1'b1;
          break;
        end
        k++;
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL ready_wait_r%0d: got no ready for byte %0d required accept", who, i);
        set_byte(who, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk); #1;
    end
    set_byte(who, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (k < 3000) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
      k++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got busy=%b required 0", name, bus.busy);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d unsent bytes required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.cs_n, bus.grant, bus.tx_send, bus.tx_data, bus.r0_ready, bus.r1_ready}
        !== {1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b cs_n=%b grant=%b send=%b data=%h rdy=%b%b required 0 11 00 0 00 00",
               bus.busy, bus.cs_n, bus.grant, bus.tx_send, bus.tx_data, bus.r1_ready, bus.r0_ready);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.cs_n, bus.grant} !== {1'b0, 2'b11, 2'b00}) begin
      bad++;
      $display("FAIL idle_no_req: got busy=%b cs_n=%b grant=%b required 0 11 00",
               bus.busy, bus.cs_n, bus.grant);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    push_frame(0, 8'h53, 1, 8'h01, 1'b0);
    start_frame(0, 8'h53, ok);
    if (ok) feed_bytes(0, 1, 8'h01, 1'b0, 0, 1'b0);
    wait_idle("single");
    total++;
    if (bus.cs_n !== 2'b11) begin
      bad++;
      $display("FAIL single_cs_release: got %b required 11", bus.cs_n);
    end
  endtask

  task automatic test_contention();
    bit ok0, ok1;
    do_reset();
    push_frame(0, 8'h11, 1, 8'h22, 1'b0);
    push_frame(1, 8'h20, 3, 8'hAA, 1'b0);
    fork
      begin
        start_frame(0, 8'h11, ok0);
        if (ok0) feed_bytes(0, 1, 8'h22, 1'b0, 0, 1'b0);
      end
      begin
        start_frame(1, 8'h20, ok1);
        if (ok1) feed_bytes(1, 3, 8'hAA, 1'b0, 0, 1'b0);
      end
    join
    wait_idle("contention");
  endtask

  task automatic test_withhold();
    bit ok;
    int s0;
    push_frame(1, 8'h5C, 1, 8'h41, 1'b0);
    start_frame(1, 8'h5C, ok);
    s0 = send_count;
    if (ok) feed_bytes(1, 1, 8'h41, 1'b0, 50, 1'b0);
    wait_idle("withhold");
    total++;
    if (send_count - s0 !== 2) begin
      bad++;
      $display("FAIL withhold_sends: got %0d required 2", send_count - s0);
    end
  endtask

  task automatic test_spurious_done();
    bit ok;
    int s0;
    int k;
    push_frame(0, 8'h5A, 2, 8'h01, 1'b1);
    s0 = send_count;
    start_frame(0, 8'h5A, ok);
    if (ok) feed_bytes(0, 2, 8'h01, 1'b1, 10, 1'b1);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (bus.grant === 2'b00) break;
      k++;
    end
    @(posedge clk); #1;
    spur_pending = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.cs_n, bus.tx_send} !== {1'b1, 2'b11, 1'b0}) begin
      bad++;
      $display("FAIL gap_spurious: got busy=%b cs_n=%b send=%b required 1 11 0",
               bus.busy, bus.cs_n, bus.tx_send);
    end
    wait_idle("spurious");
    total++;
    if (send_count - s0 !== 3) begin
      bad++;
      $display("FAIL spurious_sends: got %0d required 3", send_count - s0);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int k;
    do_reset();
    push_frame(0, 8'h33, 1, 8'h44, 1'b0);
    start_frame(0, 8'h33, ok);
    set_byte(0, 1'b1, 8'h44, 1'b0);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (bus.r0_ready === 1'b1) break;
      k++;
    end
    @(posedge clk); #1;
    set_byte(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'h66);
    total++;
    if ({bus.busy, bus.tx_send, bus.cs_n} !== {1'b1, 1'b0, 2'b10}) begin
      bad++;
      $display("FAIL pre_reset_wait: got busy=%b send=%b cs_n=%b required 1 0 10",
               bus.busy, bus.tx_send, bus.cs_n);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.cs_n, bus.grant, bus.tx_send, bus.tx_data, bus.r0_ready, bus.r1_ready}
        !== {1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_outputs: got busy=%b cs_n=%b grant=%b send=%b data=%h required 0 11 00 0 00",
               bus.busy, bus.cs_n, bus.grant, bus.tx_send, bus.tx_data);
    end
    exp_q.delete();
    push_frame(1, 8'h66, 1, 8'h77, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus.grant !== 2'b00) break;
      k++;
    end
    total++;
    if (bus.grant !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_grant: got %b required 10", bus.grant);
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h66);
    feed_bytes(1, 1, 8'h77, 1'b0, 0, 1'b0);
    wait_idle("reset_mid");
  endtask

  task automatic test_long_frame();
    bit ok;
    int s0;
    ser_lat = 16;
    push_frame(1, 8'hC3, 2048, 8'h00, 1'b1);
    s0 = send_count;
    start_frame(1, 8'hC3, ok);
    if (ok) feed_bytes(1, 2048, 8'h00, 1'b1, 0, 1'b0);
    wait_idle("long");
    total++;
    if (send_count - s0 !== 2049) begin
      bad++;
      $display("FAIL long_sends: got %0d required 2049", send_count - s0);
    end
    ser_lat = 3;
  endtask

  initial begin
    bus.r0_req = 1'b0; bus.r0_cmd = 8'h00; bus.r0_data = 8'h00;
    bus.r0_valid = 1'b0; bus.r0_last = 1'b0;
    bus.r1_req = 1'b0; bus.r1_cmd = 8'h00; bus.r1_data = 8'h00;
    bus.r1_valid = 1'b0; bus.r1_last = 1'b0;
    test_reset();
    test_single_frame();
    test_contention();
    test_withhold();
    test_spurious_done();
    test_reset_mid_frame();
    test_long_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
